cpu_run_controller: RTL
=======================

// Module: cpu_run_controller
// PURPOSE
//  Sequences execution of the Hack CPU on one clock: CPU reset hold, free-run, pause and
//  single-step from the step button, stop at FINAL_PC, optional PC breakpoint.
//  Drives the CPU clock-enable, so the top level no longer gates the clock.
//  Counts executed cycles for the perf display.
//  Sits between the board inputs (SW, BUTTON) and the cpu / perf_counter instances.
// PARAMETERS
//  PC_WIDTH          12          width of the instruction address (log2 ROM_REGISTER_COUNT)
//  FINAL_PC          12'hFFF     PC value at which the program counts as finished
//  RESET_HOLD_CYCLES 4           cycles cpu_resetN is held low after resetN releases
//  DEBOUNCE_CYCLES   500000      stable cycles required on the step button (10 ms @ 50 MHz)
//  CYCLE_CNT_WIDTH   32          width of cycle_count
// PORTS
//  CLK_50       in   1               system clock
//  resetN       in   1               async active-low reset
//  run_sw       in   1               SW[0]: 1 = free-run, 0 = pause/step mode
//  step_btnN    in   1               raw BUTTON[1], active-low, asynchronous
//  pc           in   PC_WIDTH        current CPU instruction address
//  break_pc     in   PC_WIDTH        breakpoint address (ignored unless BREAKPOINT_EN)
//  cpu_en       out  1               CPU clock enable; CPU state advances only when 1
//  cpu_resetN   out  1               active-low reset to cpu
//  state        out  3               run_state_t, for LEDs/debug
//  finished     out  1               1 while in S_DONE
//  cycle_count  out  CYCLE_CNT_WIDTH cycles with cpu_en=1
// BEHAVIOUR
//  Reset (async, resetN=0): state=S_RESET, cpu_resetN=0, cpu_en=0, finished=0, cycle_count=0,
//   hold counter=0, bp_armed=1.
//  S_RESET: hold counter counts; after RESET_HOLD_CYCLES cycles, cpu_resetN=1 (registered),
//   next state = run_sw ? S_RUN : S_PAUSE.
//  S_RUN: cpu_en = (pc!=FINAL_PC) && !bp_hit, combinational, so no instruction at FINAL_PC or
//   at a breakpoint executes. pc==FINAL_PC -> S_DONE; else bp_hit -> S_BREAK;
//   else !run_sw -> S_PAUSE.
//  S_PAUSE: cpu_en=0. run_sw -> S_RUN (wins over a same-cycle step pulse, which is dropped).
//   Else step_pulse -> S_STEP.
//  S_STEP: exactly one cycle with cpu_en=1, then S_PAUSE. If pc==FINAL_PC on entry: cpu_en=0,
//   next state S_DONE.
//  S_BREAK: cpu_en=0, bp_armed=0. step_pulse -> S_STEP. !run_sw -> S_PAUSE.
//  S_DONE: cpu_en=0, finished=1. Sticky until resetN; run_sw and step ignored.
//  Priority in one cycle: FINAL_PC > breakpoint > run_sw > step_pulse.
//  step_pulse: 2-FF synchroniser, then debounce; one CLK_50-cycle pulse when the filtered level
//   goes 1->0 (press). Holding the button gives one pulse.
//  cycle_count: +1 each cycle cpu_en=1; saturates at all-ones, no wrap.
//  Mid-operation resetN: async return to the reset values above. A debounce in progress is discarded.
// CONFIGURATION
//  BREAKPOINT_EN defined: bp_hit = bp_armed && pc==break_pc. bp_armed is set again once
//   pc!=break_pc, so resuming does not re-trap on the same instruction.
//  BREAKPOINT_EN undefined: bp_hit=0, S_BREAK unreachable, break_pc unused.
// STRUCTURE
//  hack_ctrl_pkg: typedef enum logic [2:0] run_state_t {S_RESET=0, S_RUN=1, S_PAUSE=2,
//   S_STEP=3, S_BREAK=4, S_DONE=5}; shared with perf_counter/LED decode.
//  Sub-module button_debounce (#DEBOUNCE_CYCLES): sync, stability counter, press pulse.
//  FSM, hold counter, cycle counter and breakpoint logic stay in this module.
// TESTING  (DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=4 in sim)
//  1. Release resetN, run_sw=1, pc ramps 0.. -> cpu_resetN rises after 4 cycles, then S_RUN,
//     cpu_en=1, cycle_count increments each cycle.
//  2. run_sw=1, pc reaches 12'hFFF -> cpu_en=0 in that same cycle, next S_DONE, finished=1.
//     cycle_count frozen; toggling run_sw/step has no effect until resetN.
//  3. run_sw=0, one clean press (held 20 cycles) -> exactly one cpu_en=1 cycle, cycle_count +1.
//     A 2-cycle glitch gives no step.
//  4. BREAKPOINT_EN, break_pc=12'h010, run_sw=1 -> stop with pc=0x010, cpu_en=0, S_BREAK.
//     Press step -> one cycle, pc moves on, S_PAUSE. Re-trap at 0x010 only on a later revisit.
//  5. S_PAUSE, step pulse in the same cycle run_sw rises -> S_RUN, no S_STEP visit.
//  6. Assert resetN low during S_STEP and during a debounce -> all outputs at reset values
//     immediately; no step pulse after release.

Source files
------------

// File: rtl/cpu_run_controller_pkg.sv
// Shared types for the Hack CPU run controller: run-state encoding used by the
// controller, perf_counter and the LED decode.
package cpu_run_controller_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_RESET = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_STEP  = 3'd3,
        S_BREAK = 3'd4,
        S_DONE  = 3'd5
    } run_state_t;

    // Raw encoding of a run state, for plain-vector state registers and LED buses.
    function automatic logic [STATE_W-1:0] state_code(input run_state_t s);
        return STATE_W'(s);
    endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// Board/CPU-facing signal bundle of the run controller.
// master = board + CPU side, slave = cpu_run_controller.
interface cpu_run_controller_if
    import cpu_run_controller_pkg::*;
#(
    parameter int unsigned PC_WIDTH        = 12,
    parameter int unsigned CYCLE_CNT_WIDTH = 32
);
    logic                       run_sw;
    logic                       step_btnN;
    logic [PC_WIDTH-1:0]        pc;
    logic [PC_WIDTH-1:0]        break_pc;
    logic                       cpu_en;
    logic                       cpu_resetN;
    logic [STATE_W-1:0]         state;
    logic                       finished;
    logic [CYCLE_CNT_WIDTH-1:0] cycle_count;

    modport master (
        output run_sw, step_btnN, pc, break_pc,
        input  cpu_en, cpu_resetN, state, finished, cycle_count
    );

    modport slave (
        input  run_sw, step_btnN, pc, break_pc,
        output cpu_en, cpu_resetN, state, finished, cycle_count
    );
endinterface

// File: rtl/cpu_run_controller_button_debounce.sv
// Step-button conditioner: 2-FF synchroniser, stability-count debounce and a
// single-cycle pulse on each filtered press (1->0 of the active-low level).
module cpu_run_controller_button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press_pulse
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pulse_q;

    // Idle (released) button reads 1, so the synchroniser and filter reset high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_n};
            pulse_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
                pulse_q <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Hack CPU run controller: reset hold, free-run, pause/single-step, stop at
// FINAL_PC and cycle counting. Optional PC breakpoint under `BREAKPOINT_EN.
module cpu_run_controller
    import cpu_run_controller_pkg::*;
#(
    parameter int unsigned         PC_WIDTH          = 12,
    parameter logic [PC_WIDTH-1:0] FINAL_PC          = {PC_WIDTH{1'b1}},
    parameter int unsigned         RESET_HOLD_CYCLES = 4,
    parameter int unsigned         DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned         CYCLE_CNT_WIDTH   = 32
) (
    input  logic                 CLK_50,
    input  logic                 resetN,
    cpu_run_controller_if.slave  bus
);
    localparam int unsigned HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    localparam logic [STATE_W-1:0] ST_RESET = state_code(S_RESET);
    localparam logic [STATE_W-1:0] ST_RUN   = state_code(S_RUN);
    localparam logic [STATE_W-1:0] ST_PAUSE = state_code(S_PAUSE);
    localparam logic [STATE_W-1:0] ST_STEP  = state_code(S_STEP);
    localparam logic [STATE_W-1:0] ST_BREAK = state_code(S_BREAK);
    localparam logic [STATE_W-1:0] ST_DONE  = state_code(S_DONE);

    logic [STATE_W-1:0]         state_q;
    logic [STATE_W-1:0]         state_d;
    logic [HOLD_W-1:0]          hold_cnt_q;
    logic                       cpu_resetn_q;
    logic                       finished_q;
    logic [CYCLE_CNT_WIDTH-1:0] cycle_cnt_q;
    logic                       cpu_en_c;
    logic                       hold_done_c;
    logic                       at_final_c;
    logic                       bp_hit_c;
    logic                       step_pulse;

    cpu_run_controller_button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk         (CLK_50),
        .rst_n       (resetN),
        .btn_n       (bus.step_btnN),
        .press_pulse (step_pulse)
    );

    assign hold_done_c = (hold_cnt_q == HOLD_LAST);
    assign at_final_c  = (bus.pc == FINAL_PC);

`ifdef BREAKPOINT_EN
    logic bp_armed_q;

    // Disarm while parked at the breakpoint; re-arm once the PC has left it.
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            bp_armed_q <= 1'b1;
        end else if (state_q == ST_BREAK) begin
            bp_armed_q <= 1'b0;
        end else if (bus.pc != bus.break_pc) begin
            bp_armed_q <= 1'b1;
        end
    end

    assign bp_hit_c = bp_armed_q && (bus.pc == bus.break_pc);
`else
    logic unused_break_pc;
    assign unused_break_pc = ^bus.break_pc;
    assign bp_hit_c        = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the combinational CPU clock enable.
    always_comb begin
        state_d  = state_q;
        cpu_en_c = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (hold_done_c) begin
                    state_d = bus.run_sw ? ST_RUN : ST_PAUSE;
                end
            end
            ST_RUN: begin
                cpu_en_c = !at_final_c && !bp_hit_c;
                if (at_final_c) begin
                    state_d = ST_DONE;
                end else if (bp_hit_c) begin
                    state_d = ST_BREAK;
                end else if (!bus.run_sw) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (bus.run_sw) begin
                    state_d = ST_RUN;
                end else if (step_pulse) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                cpu_en_c = !at_final_c;
                state_d  = at_final_c ? ST_DONE : ST_PAUSE;
            end
            ST_BREAK: begin
                if (!bus.run_sw) begin
                    state_d = ST_PAUSE;
                end else if (step_pulse) begin
                    state_d = ST_STEP;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Reset-hold counter; CPU reset releases on the same edge the FSM leaves S_RESET.
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            hold_cnt_q   <= '0;
            cpu_resetn_q <= 1'b0;
        end else begin
            if (state_q == ST_RESET && !hold_done_c) begin
                hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
            cpu_resetn_q <= (state_d != ST_RESET);
        end
    end

    // Finished flag and saturating executed-cycle counter.
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            finished_q  <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            finished_q <= (state_d == ST_DONE);
            if (cpu_en_c && (cycle_cnt_q != {CYCLE_CNT_WIDTH{1'b1}})) begin
                cycle_cnt_q <= cycle_cnt_q + CYCLE_CNT_WIDTH'(1);
            end
        end
    end

    assign bus.cpu_en      = cpu_en_c;
    assign bus.cpu_resetN  = cpu_resetn_q;
    assign bus.state       = state_q;
    assign bus.finished    = finished_q;
    assign bus.cycle_count = cycle_cnt_q;

endmodule
